// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions: datapath widths, base opcodes and the fetch
// buffer entry type used between the fetch unit and the control decoder.
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Major opcodes (inst[6:0]) understood by the control decoder.
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_CALCI  = 7'b0010011,
        OPC_CALC   = 7'b0110011
    } opcode_e;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Clear the byte offset so every PC names a whole word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory port, the redirect input and the decoder
// handshake of the fetch unit. The fetch unit uses the master view.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc, opcode, funct3, funct7,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc, opcode, funct3, funct7,
        output inst_ready
    );

endinterface

// File: rtl/instr_fetch_unit_chk.sv
// Protocol checker for the fetch buffer: the issue credit must always leave a
// slot for every response that is kept.
module instr_fetch_unit_chk (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_i && !pop_i));

endmodule

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO of fetched instructions. Push and pop may happen in
// the same cycle, also when full; flush empties it and overrides a push.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next pointer/count values; a push into a full FIFO only lands with a pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
            do_push_s = push_i && ((count_q != DEPTH_C) || do_pop_s);
            wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order word reads to imem, buffers the
// returned words with their PCs and hands them to the decoder one at a time.
// A redirect discards buffered words and lets in-flight responses drain away.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    fetch_entry_t     fifo_head_s;
    fetch_entry_t     push_data_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic [SUM_W-1:0] credit_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             resp_keep_s;
    logic             resp_drop_s;
    logic             push_s;
    logic             pop_s;
    logic             inst_valid_s;

    // Handshake decode. Words still to be dropped keep holding issue credit.
    always_comb begin
        credit_s     = {2'b00, inflight_q} + {2'b00, drop_cnt_q} + {2'b00, fifo_count_s};
        req_valid_s  = !rst && !bus.redirect_valid && (credit_s < DEPTH_SUM);
        req_fire_s   = req_valid_s && bus.imem_req_ready;
        resp_keep_s  = bus.imem_resp_valid && (drop_cnt_q == CNT_ZERO);
        resp_drop_s  = bus.imem_resp_valid && (drop_cnt_q != CNT_ZERO);
        push_s       = resp_keep_s && !bus.redirect_valid && !rst;
        inst_valid_s = !fifo_empty_s && !bus.redirect_valid && !rst;
        pop_s        = inst_valid_s && bus.inst_ready;
        push_data_s  = '{pc: resp_pc_q, inst: bus.imem_resp_data};
    end

    // PC and outstanding-request bookkeeping; redirect overrides normal flow.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            pc_d       = word_align(bus.redirect_pc);
            resp_pc_d  = word_align(bus.redirect_pc);
            inflight_d = CNT_ZERO;
            if (bus.imem_resp_valid) begin
                drop_cnt_d = drop_cnt_q + inflight_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q + inflight_q;
            end
        end else begin
            pc_d       = req_fire_s  ? (pc_q + 32'd4) : pc_q;
            resp_pc_d  = resp_keep_s ? (resp_pc_q + 32'd4) : resp_pc_q;
            drop_cnt_d = resp_drop_s ? (drop_cnt_q - CNT_ONE) : drop_cnt_q;
            case ({req_fire_s, resp_keep_s})
                2'b10:   inflight_d = inflight_q + CNT_ONE;
                2'b01:   inflight_d = inflight_q - CNT_ONE;
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= CNT_ZERO;
            drop_cnt_q <= CNT_ZERO;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    instr_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (bus.redirect_valid),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

    instr_fetch_unit_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .full_i (fifo_full_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_s;
    assign bus.inst           = fifo_head_s.inst;
    assign bus.inst_pc        = fifo_head_s.pc;
    assign bus.opcode         = fifo_head_s.inst[6:0];
    assign bus.funct3         = fifo_head_s.inst[14:12];
    assign bus.funct7         = fifo_head_s.inst[31:25];

endmodule
